// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: byte-addressed instruction memory with wait-stated fetch port and byte-serial loader.
// Define IMEM_ALIGN_CHECK_EN to turn misaligned fetches into error responses.
module imem_fetch_unit #(
  parameter int unsigned MEM_NBYTE   = 4096,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  input  logic [31:0]                  req_addr_i,
  output logic                         req_ready_o,
  output logic                         rsp_valid_o,
  output logic [31:0]                  rsp_inst_o,
  output logic                         rsp_err_o,
  input  logic                         load_en_i,
  input  logic                         load_valid_i,
  input  logic [7:0]                   load_byte_i,
  output logic                         load_ready_o,
  output logic [$clog2(MEM_NBYTE)-1:0] load_ptr_o,
  output logic                         load_wrap_o
);
  localparam int AW = $clog2(MEM_NBYTE);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, LOAD} state_e;
  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          wrap_q, wrap_d;
  logic [31:0]   inst_q, inst_d;
  logic          err_q, err_d;
  logic [7:0]    mem [MEM_NBYTE];
  logic [31:0]   a;
  logic          bad;
  logic [AW-1:0] wa;
  logic [31:0]   word;
  // With no wait states the word is captured on the accepting edge, so read the live address in IDLE.
  assign a = state_q == IDLE ? req_addr_i : addr_q;
`ifdef IMEM_ALIGN_CHECK_EN
  assign bad = (a > 32'(MEM_NBYTE - 4)) || (a[1:0] != 2'b00);
`else
  assign bad = a > 32'(MEM_NBYTE - 4);
`endif
  assign wa   = {a[AW-1:2], 2'b00};
  assign word = {mem[wa + AW'(3)], mem[wa + AW'(2)], mem[wa + AW'(1)], mem[wa]};
  assign req_ready_o  = state_q == IDLE && !load_en_i;
  assign load_ready_o = state_q == LOAD && load_en_i;
  assign rsp_valid_o  = state_q == RESP;
  assign rsp_inst_o   = inst_q;
  assign rsp_err_o    = err_q;
  assign load_ptr_o   = ptr_q;
  assign load_wrap_o  = wrap_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    wrap_d  = 1'b0;
    inst_d  = inst_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:
        if (load_en_i) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (req_valid_i) begin
          addr_d  = req_addr_i;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
        end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP: state_d = IDLE;
      LOAD:
        if (!load_en_i) state_d = IDLE;
        else if (load_valid_i) begin
          ptr_d  = ptr_q + AW'(1);
          wrap_d = ptr_q == AW'(MEM_NBYTE - 1);
        end
    endcase
    if (state_d == RESP) begin
      inst_d = bad ? NOP_INST : word;
      err_d  = bad;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst && load_ready_o && load_valid_i) mem[ptr_q] <= load_byte_i;
endmodule
